// File: rtl/bch_decode_sequencer.sv
// Frame-level controller for the BCH correction core: collects a syndrome frame,
// re-arms the core, streams the frame, waits for the result and reports status.
module bch_decode_sequencer #(
  parameter int unsigned SYM_W   = 13,
  parameter int unsigned NWORDS  = 17,
  parameter int unsigned GAP     = 11,
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned T_MAX   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_word,
  input  logic             in_last,
  output logic             core_start,
  output logic [SYM_W-1:0] core_gsynd,
  input  logic             core_error_finish,
  input  logic [3:0]       core_error_number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_err_num,
  output logic             out_fail,
  output logic             out_timeout,
  output logic             out_short,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS + 1) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ARM,
    S_STREAM,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [SYM_W-1:0] word_buf_q [NWORDS];
  logic [SYM_W-1:0] word_buf_d [NWORDS];

  logic             in_ready_d;
  logic             core_start_d;
  logic [SYM_W-1:0] core_gsynd_d;
  logic             out_valid_d;
  logic [3:0]       out_err_num_d;
  logic             out_fail_d;
  logic             out_timeout_d;
  logic             out_short_d;
  logic             busy_d;
  logic [15:0]      frame_cnt_d;

  // State, counters, frame buffer and all outputs are registered together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gcnt_q      <= '0;
      tcnt_q      <= '0;
      word_buf_q  <= '{default: '0};
      in_ready    <= 1'b0;
      core_start  <= 1'b0;
      core_gsynd  <= '0;
      out_valid   <= 1'b0;
      out_err_num <= '0;
      out_fail    <= 1'b0;
      out_timeout <= 1'b0;
      out_short   <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gcnt_q      <= gcnt_d;
      tcnt_q      <= tcnt_d;
      word_buf_q  <= word_buf_d;
      in_ready    <= in_ready_d;
      core_start  <= core_start_d;
      core_gsynd  <= core_gsynd_d;
      out_valid   <= out_valid_d;
      out_err_num <= out_err_num_d;
      out_fail    <= out_fail_d;
      out_timeout <= out_timeout_d;
      out_short   <= out_short_d;
      busy        <= busy_d;
      frame_cnt   <= frame_cnt_d;
    end
  end

  // Next-state logic; output next values follow from the next state so each
  // output is aligned with the state it belongs to.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    gcnt_d        = gcnt_q;
    tcnt_d        = tcnt_q;
    word_buf_d    = word_buf_q;
    core_gsynd_d  = '0;
    out_err_num_d = out_err_num;
    out_fail_d    = out_fail;
    out_timeout_d = out_timeout;
    out_short_d   = out_short;
    frame_cnt_d   = frame_cnt;

    case (state_q)
      S_IDLE: begin
        // Zeroed buffer provides the padding for short frames.
        idx_d      = '0;
        word_buf_d = '{default: '0};
        state_d    = S_COLLECT;
      end
      S_COLLECT: begin
        if (in_valid && in_ready) begin
          word_buf_d[idx_q] = in_word;
          idx_d             = idx_q + IW'(1);
          if (in_last || (idx_q == IW'(NWORDS - 1))) begin
            state_d     = S_ARM;
            gcnt_d      = '0;
            out_short_d = (idx_q != IW'(NWORDS - 1));
          end
        end
      end
      S_ARM: begin
        if (gcnt_q == GW'(GAP - 1)) begin
          state_d      = S_STREAM;
          idx_d        = '0;
          tcnt_d       = '0;
          core_gsynd_d = word_buf_q[0];
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      S_STREAM: begin
        tcnt_d = tcnt_q + TW'(1);
        if (idx_q == IW'(NWORDS - 1)) begin
          state_d = S_WAIT;
        end else begin
          idx_d        = idx_q + IW'(1);
          core_gsynd_d = word_buf_q[idx_q + IW'(1)];
        end
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (core_error_finish) begin
          state_d       = S_REPORT;
          out_err_num_d = core_error_number;
          out_fail_d    = (core_error_number > 4'(T_MAX));
          out_timeout_d = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d       = S_REPORT;
          out_err_num_d = '0;
          out_fail_d    = 1'b1;
          out_timeout_d = 1'b1;
        end
      end
      S_REPORT: begin
        if (out_valid && out_ready) begin
          state_d       = S_IDLE;
          frame_cnt_d   = frame_cnt + 16'(1);
          out_err_num_d = '0;
          out_fail_d    = 1'b0;
          out_timeout_d = 1'b0;
          out_short_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d   = (state_d == S_COLLECT);
    core_start_d = (state_d == S_STREAM) || (state_d == S_WAIT);
    out_valid_d  = (state_d == S_REPORT);
    busy_d       = (state_d != S_IDLE);
  end

endmodule
